// File: rtl/instruction_loader.sv
// Instruction-memory load port: assembles UART bytes (MSB first) into 32-bit words,
// writes them sequentially from address 0 and holds the PC until the terminator word.
module instruction_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF,
    parameter int          TIMEOUT  = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic              wr_instruction,
    output logic [31:0]       data_instruction,
    output logic [ADDR_W-1:0] wr_address,
    output logic              stopPC_debug,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    localparam int            TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         asm_q, asm_d;
    logic [31:0]         data_q, data_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     word_cnt_inc;
    logic [31:0]         asm_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            asm_q      <= '0;
            data_q     <= '0;
            byte_idx_q <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            data_q     <= data_d;
            byte_idx_q <= byte_idx_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        data_d       = data_q;
        byte_idx_d   = byte_idx_q;
        tmo_d        = tmo_q;
        addr_d       = addr_q;
        word_cnt_d   = word_cnt_q;
        word_cnt_inc = word_cnt_q + 1'b1;
        asm_shift    = {asm_q[23:0], rx_data};

        case (state_q)
            IDLE, DONE, ERROR: begin
                // a byte arriving together with load_start is dropped
                if (load_start) begin
                    state_d    = RECV;
                    byte_idx_d = '0;
                    tmo_d      = '0;
                    addr_d     = '0;
                    word_cnt_d = '0;
                end
            end
            RECV: begin
                if (rx_done) begin
                    asm_d = asm_shift;
                    tmo_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        data_d     = asm_shift;
                        byte_idx_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else if (byte_idx_q != 2'd0) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d    = ERROR;
                        byte_idx_d = '0;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_inc;
                tmo_d      = '0;
                // a byte landing on the write cycle starts the next word
                if (rx_done) begin
                    asm_d      = asm_shift;
                    byte_idx_d = 2'd1;
                end
                if (data_q == END_WORD) begin
                    state_d    = DONE;
                    byte_idx_d = '0;
                end else if (word_cnt_inc == DEPTH) begin
                    state_d    = ERROR;
                    byte_idx_d = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_instruction   = (state_q == WRITE);
    assign data_instruction = data_q;
    assign wr_address       = addr_q;
    assign stopPC_debug     = (state_q == RECV) || (state_q == WRITE);
    assign load_done        = (state_q == DONE);
    assign load_error       = (state_q == ERROR);
    assign word_count       = word_cnt_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a small memory (ADDR_W=2) and short timeout.
module tb_instruction_loader;

    localparam int AW  = 2;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          wr_instruction;
    logic [31:0]   data_instruction;
    logic [AW-1:0] wr_address;
    logic          stopPC_debug;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   word_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] log_data[$];
    int          log_addr[$];
    logic [31:0] exp_data[$];
    int          exp_addr[$];

    instruction_loader #(.ADDR_W(AW), .END_WORD(32'hFFFF_FFFF), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .rx_data          (rx_data),
        .rx_done          (rx_done),
        .wr_instruction   (wr_instruction),
        .data_instruction (data_instruction),
        .wr_address       (wr_address),
        .stopPC_debug     (stopPC_debug),
        .load_done        (load_done),
        .load_error       (load_error),
        .word_count       (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_instruction) begin
            log_data.push_back(data_instruction);
            log_addr.push_back(int'(wr_address));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // all stimulus tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] d, input int a);
        exp_data.push_back(d);
        exp_addr.push_back(a);
    endtask

    initial begin
        rst        = 1'b0;
        load_start = 1'b0;
        rx_data    = 8'h00;
        rx_done    = 1'b0;
        #12;
        chk("rst_wr",    {31'd0, wr_instruction}, 32'd0);
        chk("rst_data",  data_instruction, 32'd0);
        chk("rst_addr",  32'(wr_address), 32'd0);
        chk("rst_stop",  {31'd0, stopPC_debug}, 32'd0);
        chk("rst_done",  {31'd0, load_done}, 32'd0);
        chk("rst_err",   {31'd0, load_error}, 32'd0);
        chk("rst_wcnt",  32'(word_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // basic load: one word plus terminator
        start_load();
        chk("t1_stop_on", {31'd0, stopPC_debug}, 32'd1);
        send_byte(8'h12); idle(1);
        send_byte(8'h34); idle(1);
        send_byte(8'h56); idle(1);
        chk("t1_no_wr_early", {31'd0, wr_instruction}, 32'd0);
        send_byte(8'h78);
        chk("t1_wr_strobe", {31'd0, wr_instruction}, 32'd1);
        chk("t1_wr_addr",   32'(wr_address), 32'd0);
        chk("t1_wr_data",   data_instruction, 32'h1234_5678);
        expect_write(32'h1234_5678, 0);
        idle(1);
        chk("t1_wr_width",  {31'd0, wr_instruction}, 32'd0);
        chk("t1_wcnt1",     32'(word_count), 32'd1);
        chk("t1_data_hold", data_instruction, 32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        chk("t1_term_addr", 32'(wr_address), 32'd1);
        chk("t1_term_stop", {31'd0, stopPC_debug}, 32'd1);
        expect_write(32'hFFFF_FFFF, 1);
        idle(1);
        chk("t1_done",      {31'd0, load_done}, 32'd1);
        chk("t1_stop_off",  {31'd0, stopPC_debug}, 32'd0);
        chk("t1_wcnt2",     32'(word_count), 32'd2);
        idle(3);
        chk("t1_done_hold", {31'd0, load_done}, 32'd1);

        // byte gap of TIMEOUT idle cycles
        start_load();
        chk("t2_done_clr",  {31'd0, load_done}, 32'd0);
        chk("t2_wcnt_clr",  32'(word_count), 32'd0);
        send_byte(8'hDE);
        send_byte(8'hAD);
        idle(TMO - 1);
        chk("t2_no_err_yet", {31'd0, load_error}, 32'd0);
        idle(1);
        chk("t2_err",       {31'd0, load_error}, 32'd1);
        chk("t2_stop_off",  {31'd0, stopPC_debug}, 32'd0);
        chk("t2_wcnt",      32'(word_count), 32'd0);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("t2_err_hold",  {31'd0, load_error}, 32'd1);

        // gap of TIMEOUT-1 cycles is tolerated, then fill memory to overflow
        start_load();
        chk("t3_err_clr",   {31'd0, load_error}, 32'd0);
        send_byte(8'hA1);
        send_byte(8'hB2);
        idle(TMO - 1);
        send_byte(8'hC3);
        send_byte(8'hD4);
        chk("t3_no_err",    {31'd0, load_error}, 32'd0);
        chk("t3_wr_strobe", {31'd0, wr_instruction}, 32'd1);
        chk("t3_wr_data",   data_instruction, 32'hA1B2_C3D4);
        expect_write(32'hA1B2_C3D4, 0);
        // next byte lands on the write cycle and must become the next MSB
        send_word(32'h1122_3344);
        expect_write(32'h1122_3344, 1);
        send_byte(8'h55);
        send_byte(8'h66);
        start_load();
        chk("t3_restart_ign", {31'd0, stopPC_debug}, 32'd1);
        send_byte(8'h77);
        send_byte(8'h88);
        chk("t3_addr2",     32'(wr_address), 32'd2);
        expect_write(32'h5566_7788, 2);
        send_word(32'h99AA_BBCC);
        chk("t3_addr3",     32'(wr_address), 32'd3);
        chk("t3_last_data", data_instruction, 32'h99AA_BBCC);
        expect_write(32'h99AA_BBCC, 3);
        idle(1);
        chk("t3_ovf_err",   {31'd0, load_error}, 32'd1);
        chk("t3_ovf_wcnt",  32'(word_count), 32'd4);
        chk("t3_ovf_stop",  {31'd0, stopPC_debug}, 32'd0);
        chk("t3_ovf_wr",    {31'd0, wr_instruction}, 32'd0);
        chk("t3_done_low",  {31'd0, load_done}, 32'd0);

        // reset mid-load, then a clean word at address 0
        start_load();
        send_byte(8'hBE);
        send_byte(8'hEF);
        rst = 1'b0;
        #2;
        chk("t4_rst_stop",  {31'd0, stopPC_debug}, 32'd0);
        chk("t4_rst_data",  data_instruction, 32'd0);
        chk("t4_rst_addr",  32'(wr_address), 32'd0);
        chk("t4_rst_wcnt",  32'(word_count), 32'd0);
        chk("t4_rst_err",   {31'd0, load_error}, 32'd0);
        #2;
        rst = 1'b1;
        idle(1);
        start_load();
        send_word(32'h0102_0304);
        chk("t4_wr_strobe", {31'd0, wr_instruction}, 32'd1);
        chk("t4_wr_addr",   32'(wr_address), 32'd0);
        chk("t4_wr_data",   data_instruction, 32'h0102_0304);
        expect_write(32'h0102_0304, 0);
        idle(1);
        chk("t4_wcnt",      32'(word_count), 32'd1);
        idle(2);

        chk("log_count", 32'(log_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < log_data.size()) begin
                chk($sformatf("log_data%0d", i), log_data[i], exp_data[i]);
                chk($sformatf("log_addr%0d", i), 32'(log_addr[i]), 32'(exp_addr[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction-memory load port: assembles a program received as a UART byte stream into 32-bit words and drives wr_instruction/data_instruction into the fetch stage's instruction memory.
- Sits between the debug unit's UART receiver and the instruction-fetch block.
- Holds the pipeline's PC frozen during the load via stopPC_debug.
- Signals completion or error to the debug unit.

Parameters:
- ADDR_W, 10, width of word address / word counter (memory depth 2**ADDR_W words)
- END_WORD, 32'hFFFF_FFFF, program terminator word; written to memory, then the load ends
- TIMEOUT, 100000, max clk cycles allowed between bytes of a partially assembled word

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low (0 = reset)
- load_start  input  1  one-cycle pulse from debug unit: begin a new program load
- rx_data  input  8  received byte from UART receiver
- rx_done  input  1  one-cycle strobe, rx_data valid
- wr_instruction  output  1  one-cycle write strobe to instruction memory
- data_instruction  output  32  word to write, valid while wr_instruction=1
- wr_address  output  ADDR_W  word address of current write
- stopPC_debug  output  1  high while loading; freezes PC update
- load_done  output  1  high (level) after terminator written, until next load_start
- load_error  output  1  high (level) after timeout/overflow, until next load_start
- word_count  output  ADDR_W+1  number of words written in the current/last load, terminator included

Behaviour:
- Reset (rst=0, async): state IDLE; wr_instruction=0, data_instruction=0, wr_address=0, stopPC_debug=0, load_done=0, load_error=0, word_count=0, byte index=0, timeout counter=0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE: stopPC_debug=0. load_start=1 -> RECV; clears word_count, wr_address, byte index, load_done, load_error.
- RECV: stopPC_debug=1. On each rx_done:
  - shift rx_data into the assembly register, first byte = bits [31:24] (MSB first);
  - byte index +1.
  - On the 4th byte -> WRITE next cycle; byte index returns to 0.
- WRITE (exactly one cycle):
  - wr_instruction=1, data_instruction=assembled word, wr_address=current address.
  - Then word_count+1.
  - If word == END_WORD -> DONE.
  - Else if word_count reaches 2**ADDR_W -> ERROR (overflow, no further writes).
  - Else wr_address+1 -> RECV.
- Latency: the write strobe is asserted exactly 1 clk after the rx_done of the 4th byte.
- rx_done arriving during WRITE is not lost: the byte is captured as byte 0 of the next word.
- Timeout: in RECV with byte index != 0, the counter increments each cycle without rx_done and resets on rx_done. Reaching TIMEOUT -> ERROR. No timeout is applied while byte index = 0, so the line may idle between words.
- DONE: load_done=1, stopPC_debug=0; hold until load_start.
- ERROR: load_error=1, stopPC_debug=0, no writes; hold until load_start. The partial word is discarded.
- load_start in RECV/WRITE: ignored; a load cannot be restarted mid-transfer.
- load_start and rx_done in the same cycle in IDLE/DONE/ERROR: the load starts and that byte is ignored.
- wr_instruction is never high in any state other than WRITE.
- data_instruction holds its last written value outside WRITE.
- Reset asserted mid-load: immediate return to IDLE; the memory content written so far is left as is.

Test Plan:
- Reset then load_start, bytes 12 34 56 78 FF FF FF FF -> writes 0x12345678 @0 and 0xFFFFFFFF @1; load_done=1, word_count=2, stopPC_debug falls after the 2nd write.
- Single write timing: 4th rx_done at cycle N -> wr_instruction=1 only at cycle N+1, one cycle wide, wr_address correct.
- Byte gap: 2 bytes sent then idle TIMEOUT cycles -> load_error=1, no write occurs.
- Same stimulus with a gap of TIMEOUT-1 cycles -> no error, word written.
- Overflow with ADDR_W=2: send 4 non-terminator words -> 4 writes at addresses 0..3, then load_error=1, word_count=4.
- rst pulled low after 2 bytes -> all outputs return to 0 immediately. A new load_start then writes the next word to address 0 with no stale bytes.
- load_start during RECV is ignored. rx_done coinciding with WRITE is captured as the next word's MSB.
